pwm_duty_decoder: RTL and testbench
===================================

# pwm_duty_decoder

Receive-side counterpart of the LED ramp PWM path. Samples an external PWM waveform of fixed frame length on `clk_div` and recovers the 8-bit duty code per frame. Tracks the ramp direction of successive codes and flags peaks and troughs. Used to loop back and check the LED brightness ramp, or to drive a second LED bank from a received PWM line.

## Interface

Parameters:
- `PERIOD`, default 256: PWM frame length in `clk_div` cycles. Power of two, at least 16.

Ports:
- `clk_div`, in, 1: block clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `pwm_in`, in, 1: PWM input, asynchronous to `clk_div`.
- `duty_out`, out, 8: last recovered duty code.
- `duty_valid`, out, 1: one-cycle pulse when `duty_out` updates.
- `ramp_dir`, out, 2: ramp direction.
  - 00 = unknown, 01 = up, 10 = down, 11 = hold.
- `peak`, out, 1: one-cycle pulse when direction goes from up to down.
- `trough`, out, 1: one-cycle pulse when direction goes from down to up.
- `static_lvl`, out, 1: high while the last 2 frames closed by timeout (no edges seen).

## Operation

- **Input synchronizer:** 2-FF synchronizer `pwm_in` → `s`, plus a delay register `s_d`.
  - `e` = `s & ~s_d` (rising edge).
- **Counters:** `cnt` (frame cycle count) and `hi` (high-sample count) are both `clog2(PERIOD)+1` bits wide.
  - Every cycle with no close or discard: `cnt <= cnt+1`, `hi <= hi+s`.
- **Close condition:** `close` = (`e` and `cnt >= PERIOD/2`) or (`cnt == PERIOD`).
  - An edge and a timeout in the same cycle are one close.
- **On close:**
  - `duty_out <= min(hi, 255)`, which saturates the all-high value PERIOD to 255.
  - `duty_valid <= primed`.
  - `cnt <= 1`, `hi <= s`: the close cycle's sample is the first sample of the new frame.
  - `primed <= 1`.
- **Short edge** (`e` and `cnt < PERIOD/2`):
  - Glitch or phase slip. The frame is discarded: no valid, `duty_out` unchanged.
  - `cnt <= 1`, `hi <= s`.
- **First frame after reset:** always discarded, because `primed` = 0. This covers partial-frame alignment.
- **Timeout counter:** `to_cnt` is 2 bits and saturating.
  - +1 on a timeout-only close (no `e`); cleared on an edge close or short edge.
  - `static_lvl` = (`to_cnt == 2`).
  - A 0% or 100% input therefore reports 0 or 255 via timeout closes and raises `static_lvl`.
- **Ramp tracker:** updates only when `duty_valid` is set. It compares the new code against `prev`, the previous valid code.
  - New code > `prev`: `ramp_dir` = 01. New code < `prev`: `ramp_dir` = 10. Equal: `ramp_dir` = 11.
  - First valid after reset: only loads `prev`; `ramp_dir` stays 00, with no `peak` or `trough`.
  - `peak` pulses when the old `ramp_dir` was 01 and the new one is 10.
  - `trough` pulses when the old `ramp_dir` was 10 and the new one is 01.
  - Hold (11) does not break a pending direction: up, hold, down does not pulse `peak`. Only a direct 01 → 10 or 10 → 01 transition counts.
  - `peak` and `trough` are registered and coincide with the same-cycle `duty_valid`.
- **Reset, including mid-frame:**
  - All synchronizer registers, `cnt`, `hi`, `to_cnt`, `prev`, and `primed` go to 0.
  - Output reset values: `duty_out` = 0, `duty_valid` = 0, `ramp_dir` = 00, `peak` = 0, `trough` = 0, `static_lvl` = 0.
  - Any partial frame is lost.

## Timing

- **Pin to edge detect:** a `pwm_in` rise captured by sync FF1 at edge N gives `s` = 1 after N+1 and `e` = 1 during the cycle after N+1.
- **Edge to outputs:**
  - `duty_out`, `duty_valid`, `ramp_dir`, `peak` and `trough` update at edge N+2.
  - Total latency is 3 `clk_div` edges from first capture.
- **Pulse width:** `duty_valid`, `peak` and `trough` are high for exactly 1 cycle.
- **Outputs stable:** `duty_out` and `ramp_dir` hold between valids.
- **Steady state:**
  - In-phase input with duty d (high d of PERIOD cycles): one valid every PERIOD cycles, `duty_out` = d. For d = PERIOD, `duty_out` = 255.
  - Timeout-only input: one valid every PERIOD cycles, counted from the previous close.
- **Throughput:** at most one valid per PERIOD/2 cycles, set by the glitch filter.

## Test plan

- **Reset values:** assert `rst` asynchronously mid-frame. All outputs read 0 immediately. After release, the first frame is discarded and no `duty_valid` occurs before the second close.
- **Steady duty:** `PERIOD` = 256, pwm duty 100/256 repeated. `duty_valid` pulses every 256 cycles with `duty_out` = 100 and `ramp_dir` = 11 from the 2nd valid on.
- **Ramp and turnaround:** duties 253, 254, 255, 254, 253, then 1, 0, 1.
  - Expect `ramp_dir` 01, 01, 10, 10.
  - `peak` pulses exactly once, with the 254 after 255.
  - `trough` pulses once, with the 1 after 0.
- **Extremes:**
  - `pwm_in` held low: `duty_out` = 0 every 256 cycles, `static_lvl` = 1 after the 2nd timeout close.
  - `pwm_in` held high: `duty_out` = 255.
  - The first rising edge clears `static_lvl`.
- **Glitch:** insert a 1-cycle high pulse 40 cycles after a frame start. No `duty_valid`, `duty_out` is unchanged, and the frame restarts at the glitch.
- **Simultaneous edge and timeout:** place the edge exactly at `cnt` = 256. There is a single `duty_valid`, and the next frame counts the edge cycle as high (`hi` starts at 1).

Source files
------------

// File: rtl/pwm_duty_decoder.sv
// Recovers the 8-bit duty code of each fixed-length PWM frame sampled on clk_div, tracks ramp direction.
// Outputs update 3 clk_div edges after a pwm_in rise is first captured; no backpressure, one result per closed frame.
module pwm_duty_decoder #(
  parameter int PERIOD = 256
) (
  input  logic       clk_div,
  input  logic       rst,
  input  logic       pwm_in,
  output logic [7:0] duty_out,
  output logic       duty_valid,
  output logic [1:0] ramp_dir,
  output logic       peak,
  output logic       trough,
  output logic       static_lvl
);

  localparam int CW = $clog2(PERIOD) + 1;
  localparam int HW = (CW > 8) ? CW : 8;
  localparam logic [CW-1:0] CNT_FULL = CW'(PERIOD);
  localparam logic [CW-1:0] CNT_HALF = CW'(PERIOD / 2);

  typedef enum logic [1:0] {
    DIR_UNK  = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10,
    DIR_HOLD = 2'b11
  } dir_t;

  logic          r_sync1;
  logic          r_s;
  logic          r_s_d;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_hi;
  logic [1:0]    r_to_cnt;
  logic          r_primed;
  logic [7:0]    r_prev;
  logic          r_prev_vld;
  logic [7:0]    r_duty;
  logic          r_valid;
  dir_t          r_dir;
  logic          r_peak;
  logic          r_trough;

  logic          w_e;
  logic          w_close;
  logic          w_short;
  logic [HW-1:0] w_hi_w;
  logic [7:0]    w_code;
  dir_t          w_dir;

  assign w_e     = r_s & ~r_s_d;
  assign w_close = (w_e && (r_cnt >= CNT_HALF)) || (r_cnt == CNT_FULL);
  assign w_short = w_e && (r_cnt < CNT_HALF);
  assign w_hi_w  = HW'(r_hi);
  assign w_code  = (w_hi_w > HW'(255)) ? 8'hFF : w_hi_w[7:0];

  always_comb begin
    w_dir = DIR_HOLD;
    if (w_code > r_prev) begin
      w_dir = DIR_UP;
    end else if (w_code < r_prev) begin
      w_dir = DIR_DOWN;
    end
  end

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_s        <= 1'b0;
      r_s_d      <= 1'b0;
      r_cnt      <= '0;
      r_hi       <= '0;
      r_to_cnt   <= 2'd0;
      r_primed   <= 1'b0;
      r_prev     <= 8'd0;
      r_prev_vld <= 1'b0;
      r_duty     <= 8'd0;
      r_valid    <= 1'b0;
      r_dir      <= DIR_UNK;
      r_peak     <= 1'b0;
      r_trough   <= 1'b0;
    end else begin
      r_sync1  <= pwm_in;
      r_s      <= r_sync1;
      r_s_d    <= r_s;
      r_valid  <= 1'b0;
      r_peak   <= 1'b0;
      r_trough <= 1'b0;

      // The sample taken in a closing cycle belongs to the next frame.
      if (w_close || w_short) begin
        r_cnt <= CW'(1);
        r_hi  <= CW'(r_s);
      end else begin
        r_cnt <= r_cnt + CW'(1);
        r_hi  <= r_hi + CW'(r_s);
      end

      // Ceiling of 2 keeps static_lvl asserted for as long as timeouts continue.
      if (w_e) begin
        r_to_cnt <= 2'd0;
      end else if (w_close && (r_to_cnt != 2'd2)) begin
        r_to_cnt <= r_to_cnt + 2'd1;
      end

      if (w_close) begin
        r_primed <= 1'b1;
        r_valid  <= r_primed;
        if (r_primed) begin
          r_duty     <= w_code;
          r_prev     <= w_code;
          r_prev_vld <= 1'b1;
          if (r_prev_vld) begin
            r_dir    <= w_dir;
            r_peak   <= (r_dir == DIR_UP) && (w_dir == DIR_DOWN);
            r_trough <= (r_dir == DIR_DOWN) && (w_dir == DIR_UP);
          end
        end
      end
    end
  end

  assign duty_out   = r_duty;
  assign duty_valid = r_valid;
  assign ramp_dir   = r_dir;
  assign peak       = r_peak;
  assign trough     = r_trough;
  assign static_lvl = (r_to_cnt == 2'd2);

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Drives grid-aligned PWM frames and compares every duty_valid against a frame-level reference model.
module tb_pwm_duty_decoder;

  localparam int P = 256;

  logic       clk_div = 1'b0;
  logic       rst;
  logic       pwm_in;
  logic [7:0] duty_out;
  logic       duty_valid;
  logic [1:0] ramp_dir;
  logic       peak;
  logic       trough;
  logic       static_lvl;

  always #5 clk_div = ~clk_div;

  pwm_duty_decoder #(.PERIOD(P)) dut (
    .clk_div    (clk_div),
    .rst        (rst),
    .pwm_in     (pwm_in),
    .duty_out   (duty_out),
    .duty_valid (duty_valid),
    .ramp_dir   (ramp_dir),
    .peak       (peak),
    .trough     (trough),
    .static_lvl (static_lvl)
  );

  typedef struct {
    int code;
    int dir;
    int pk;
    int tr;
    int st;
    int stamp;
  } rec_t;

  rec_t q_act[$];
  rec_t q_exp[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int stray  = 0;
  int dbl    = 0;
  bit last_vld = 1'b0;

  always @(posedge clk_div) cyc <= cyc + 1;

  always @(negedge clk_div) begin
    rec_t r;
    if (duty_valid === 1'b1) begin
      r.code  = int'(duty_out);
      r.dir   = int'(ramp_dir);
      r.pk    = int'(peak);
      r.tr    = int'(trough);
      r.st    = int'(static_lvl);
      r.stamp = cyc;
      q_act.push_back(r);
    end
    if (((peak | trough) === 1'b1) && (duty_valid !== 1'b1)) stray++;
    if ((duty_valid === 1'b1) && last_vld) dbl++;
    last_vld = (duty_valid === 1'b1);
  end

  // Frame-level reference: every frame on the 256-cycle grid closes at the next grid point.
  bit m_have_frame;
  bit m_end_high;
  bit m_primed;
  bit m_has_code;
  int m_code;
  int m_prev;
  int m_dir;
  int m_tcnt;
  int m_last_exp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_have_frame = 1'b0;
    m_end_high   = 1'b0;
    m_primed     = 1'b0;
    m_has_code   = 1'b0;
    m_code       = 0;
    m_prev       = 0;
    m_dir        = 0;
    m_tcnt       = 0;
    m_last_exp   = 0;
  endtask

  task automatic boundary(input bit start_high, input int t0);
    bit   is_edge;
    int   nd;
    rec_t x;
    if (!m_have_frame) return;
    is_edge = !m_end_high && start_high;
    if (is_edge) m_tcnt = 0;
    else if (m_tcnt < 2) m_tcnt = m_tcnt + 1;
    if (m_primed) begin
      x.code = m_code;
      x.pk   = 0;
      x.tr   = 0;
      if (m_has_code) begin
        nd   = (m_code > m_prev) ? 1 : ((m_code < m_prev) ? 2 : 3);
        x.pk = (m_dir == 1 && nd == 2) ? 1 : 0;
        x.tr = (m_dir == 2 && nd == 1) ? 1 : 0;
        m_dir = nd;
      end
      m_has_code = 1'b1;
      m_prev     = m_code;
      x.dir      = m_dir;
      x.st       = (m_tcnt == 2) ? 1 : 0;
      x.stamp    = t0 + 3;
      q_exp.push_back(x);
      m_last_exp = m_code;
    end
    m_primed = 1'b1;
  endtask

  // d = high cycles at frame start; g > 0 replaces the frame by a single high cycle at offset g.
  task automatic frame(input int d, input int g, input int len);
    int t0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk_div);
      pwm_in = (g > 0) ? (i == g) : (i < d);
      if (i == 0) begin
        t0 = cyc;
        boundary((g > 0) ? 1'b0 : (d > 0), t0);
      end
      if (g > 0 && i == g + 6) chk("glitch_hold", duty_out, m_last_exp);
    end
    m_have_frame = 1'b1;
    m_code       = (g > 0) ? 1 : ((d > 255) ? 255 : d);
    m_end_high   = (g > 0) ? 1'b0 : ((len - 1) < d);
    if (g > 0) m_tcnt = 0;
  endtask

  task automatic drain(input string tag);
    rec_t a;
    rec_t x;
    int   n;
    chk({tag, "_count"}, q_act.size(), q_exp.size());
    n = (q_act.size() < q_exp.size()) ? q_act.size() : q_exp.size();
    for (int k = 0; k < n; k++) begin
      a = q_act.pop_front();
      x = q_exp.pop_front();
      chk({tag, "_code"},   a.code,  x.code);
      chk({tag, "_dir"},    a.dir,   x.dir);
      chk({tag, "_peak"},   a.pk,    x.pk);
      chk({tag, "_trough"}, a.tr,    x.tr);
      chk({tag, "_static"}, a.st,    x.st);
      chk({tag, "_time"},   a.stamp, x.stamp);
    end
    q_act.delete();
    q_exp.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_duty"},   duty_out,   0);
    chk({tag, "_valid"},  duty_valid, 0);
    chk({tag, "_dir"},    ramp_dir,   0);
    chk({tag, "_peak"},   peak,       0);
    chk({tag, "_trough"}, trough,     0);
    chk({tag, "_static"}, static_lvl, 0);
  endtask

  int ramp_seq[9] = '{253, 254, 255, 254, 253, 1, 0, 1, 2};

  initial begin
    pwm_in = 1'b0;
    rst    = 1'b1;
    model_reset();
    repeat (3) @(negedge clk_div);
    check_zero("por");
    rst = 1'b0;
    repeat (5) @(negedge clk_div);

    for (int k = 0; k < 6; k++) frame(100, 0, P);
    drain("steady");

    foreach (ramp_seq[k]) frame(ramp_seq[k], 0, P);
    drain("ramp");

    frame(60, 0, P);
    frame(0, 40, P);
    frame(80, 0, P);
    frame(80, 0, P);
    drain("glitch");

    for (int k = 0; k < 4; k++) frame(0, 0, P);
    frame(30, 0, P);
    frame(30, 0, P);
    drain("low");

    for (int k = 0; k < 4; k++) frame(256, 0, P);
    frame(50, 0, P);
    frame(50, 0, P);
    drain("high");

    frame(100, 0, 130);
    @(negedge clk_div);
    #2 rst = 1'b1;
    #1 check_zero("midrst");
    drain("prerst");
    model_reset();
    repeat (3) @(negedge clk_div);
    rst = 1'b0;
    repeat (4) @(negedge clk_div);

    frame(int'($urandom_range(1, 256)), 0, P);
    for (int k = 0; k < 40; k++) frame(int'($urandom_range(0, 256)), 0, P);
    drain("rand");

    chk("stray_pulse", stray, 0);
    chk("double_valid", dbl, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
